// File: rtl/id_instr_queue.sv
// id_instr_queue: DEPTH-entry show-ahead FIFO sitting between fetch and decode.
// Each entry carries {instr, pc, btb target, taken bit}. Fetch pushes with a
// valid/ready handshake; decode pops the head the same way. A branch redirect
// (flush_i) empties the queue in one cycle and discards that cycle's push.
module id_instr_queue #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [31:0]                instr_i,
    input  logic [XLEN-1:0]            pc_i,
    input  logic [XLEN-1:0]            btb_pc_i,
    input  logic                       pred_taken_i,
    output logic                       pop_valid_o,
    input  logic                       pop_ready_i,
    output logic [31:0]                instr_o,
    output logic [XLEN-1:0]            pc_o,
    output logic [XLEN-1:0]            btb_pc_o,
    output logic                       pred_taken_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] btb_pc;
        logic            taken;
    } entry_t;

    // Storage is deliberately left unreset; occupancy alone decides validity.
    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic   full;
    logic   empty;
    logic   push_fire;
    logic   pop_fire;
    entry_t wr_entry;
    entry_t head;

    // Ready/valid come only from occupancy, so there is no path from
    // pop_ready_i to push_ready_o or from push_valid_i to pop_valid_o.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign push_ready_o = ~full;
    assign pop_valid_o  = ~empty;
    assign push_fire    = push_valid_i & ~full;
    assign pop_fire     = pop_ready_i & ~empty;
    assign count_o      = count;

    assign wr_entry = '{instr:  instr_i,
                        pc:     pc_i,
                        btb_pc: btb_pc_i,
                        taken:  pred_taken_i};

    // Write the offered bundle into the tail slot; a flushed push is dropped.
    always_ff @(posedge clk_i) begin
        if (push_fire && !flush_i) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointer and occupancy bookkeeping; flush beats push and pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Show-ahead head, forced to a harmless NOP bundle while empty.
    always_comb begin
        head         = mem[rd_ptr];
        instr_o      = NOP_INSTR;
        pc_o         = '0;
        btb_pc_o     = '0;
        pred_taken_o = 1'b0;
        if (!empty) begin
            instr_o      = head.instr;
            pc_o         = head.pc;
            btb_pc_o     = head.btb_pc;
            pred_taken_o = head.taken;
        end
    end

endmodule

// File: tb/tb_id_instr_queue.sv
// Bench for id_instr_queue: a scoreboard queue records every accepted bundle
// and each pop is compared against the oldest recorded bundle.
module tb_id_instr_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] btb;
        logic        tk;
    } bun_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        push_valid_i = 1'b0;
    logic        push_ready_o;
    logic [31:0] instr_i = '0;
    logic [31:0] pc_i = '0;
    logic [31:0] btb_pc_i = '0;
    logic        pred_taken_i = 1'b0;
    logic        pop_valid_o;
    logic        pop_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] btb_pc_o;
    logic        pred_taken_o;
    logic [2:0]  count_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_cnt    = 0;
    bun_t sb[$];

    id_instr_queue #(.XLEN(32), .DEPTH(DEPTH), .NOP_INSTR(32'h0000_0013)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .btb_pc_i(btb_pc_i), .pred_taken_i(pred_taken_i),
        .pop_valid_o(pop_valid_o), .pop_ready_i(pop_ready_i),
        .instr_o(instr_o), .pc_o(pc_o), .btb_pc_o(btb_pc_o), .pred_taken_o(pred_taken_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bun_t mk(input logic [31:0] pc);
        bun_t b;
        b.instr = $urandom;
        b.pc    = pc;
        b.btb   = pc + 32'($urandom_range(1, 64)) * 4;
        b.tk    = 1'($urandom_range(0, 1));
        return b;
    endfunction

    // One clock of stimulus; updates the reference occupancy and scoreboard.
    // Called and returns at posedge+1, when DUT outputs are settled.
    task automatic step(input logic pv, input bun_t b, input logic pr, input logic fl,
                        output bun_t head, output logic popped, output logic pushed);
        push_valid_i = pv;
        instr_i      = b.instr;
        pc_i         = b.pc;
        btb_pc_i     = b.btb;
        pred_taken_i = b.tk;
        pop_ready_i  = pr;
        flush_i      = fl;
        #1;
        head   = {instr_o, pc_o, btb_pc_o, pred_taken_o};
        pushed = pv && (m_cnt != DEPTH) && !fl;
        popped = pr && (m_cnt != 0) && !fl;
        if (fl) begin
            m_cnt = 0;
            sb.delete();
        end else begin
            if (pushed) begin sb.push_back(b); m_cnt++; end
            if (popped) m_cnt--;
        end
        @(posedge clk_i);
        #1;
        push_valid_i = 1'b0;
        pop_ready_i  = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_cnt = 0;
        sb.delete();
        @(posedge clk_i);
        #1;
        n_checks++;
        if ({push_ready_o, pop_valid_o, count_o} !== {1'b1, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b cnt=%0d want rdy=1 vld=0 cnt=0",
                     push_ready_o, pop_valid_o, count_o);
        end
        n_checks++;
        if ({instr_o, pc_o, btb_pc_o, pred_taken_o} !== {32'h13, 32'h0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_head: got instr=%h pc=%h btb=%h tk=%b want 00000013/0/0/0",
                     instr_o, pc_o, btb_pc_o, pred_taken_o);
        end
    endtask

    task automatic test_in_order();
        bun_t hd, exp;
        logic pp, pu;
        // First push into an empty queue with decode ready: must not bypass.
        step(1'b1, mk(32'h0), 1'b1, 1'b0, hd, pp, pu);
        n_checks++;
        if (count_o !== 3'd1 || pop_valid_o !== 1'b1 || pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL first_visible: got cnt=%0d vld=%b pc=%h want 1/1/0", count_o, pop_valid_o, pc_o);
        end
        step(1'b1, mk(32'h4), 1'b1, 1'b0, hd, pp, pu);
        if (pp) begin
            exp = sb.pop_front();
            n_checks++;
            if (hd !== exp) begin n_fail++; $display("FAIL inorder_pop: got %h want %h", hd, exp); end
        end
        step(1'b1, mk(32'h8), 1'b1, 1'b0, hd, pp, pu);
        if (pp) begin
            exp = sb.pop_front();
            n_checks++;
            if (hd !== exp) begin n_fail++; $display("FAIL inorder_pop: got %h want %h", hd, exp); end
        end
        for (int k = 0; k < 20 && m_cnt > 0; k++) begin
            step(1'b0, hd, 1'b1, 1'b0, hd, pp, pu);
            if (pp) begin
                exp = sb.pop_front();
                n_checks++;
                if (hd !== exp) begin n_fail++; $display("FAIL inorder_pop: got %h want %h", hd, exp); end
            end
        end
        n_checks++;
        if (count_o !== 3'd0 || pop_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL inorder_empty: got cnt=%0d vld=%b want 0/0", count_o, pop_valid_o);
        end
    endtask

    task automatic test_backpressure();
        bun_t hd, exp, b5;
        logic pp, pu;
        for (int i = 0; i < 4; i++) step(1'b1, mk(32'h100 + 32'(i) * 4), 1'b0, 1'b0, hd, pp, pu);
        n_checks++;
        if (count_o !== 3'd4 || push_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: got cnt=%0d rdy=%b want 4/0", count_o, push_ready_o);
        end
        b5 = mk(32'h110);
        step(1'b1, b5, 1'b0, 1'b0, hd, pp, pu);
        step(1'b1, b5, 1'b0, 1'b0, hd, pp, pu);
        n_checks++;
        if (count_o !== 3'd4 || push_ready_o !== 1'b0 || pc_o !== 32'h100) begin
            n_fail++;
            $display("FAIL stall_hold: got cnt=%0d rdy=%b pc=%h want 4/0/00000100", count_o, push_ready_o, pc_o);
        end
        // Full + pop + push in the same cycle: only the pop fires.
        step(1'b1, b5, 1'b1, 1'b0, hd, pp, pu);
        if (pp) begin
            exp = sb.pop_front();
            n_checks++;
            if (hd !== exp) begin n_fail++; $display("FAIL full_pop: got %h want %h", hd, exp); end
        end
        n_checks++;
        if (count_o !== 3'd3 || push_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pushpop: got cnt=%0d rdy=%b want 3/1", count_o, push_ready_o);
        end
        step(1'b1, b5, 1'b0, 1'b0, hd, pp, pu);
        n_checks++;
        if (count_o !== 3'd4) begin
            n_fail++;
            $display("FAIL fifth_accept: got cnt=%0d want 4", count_o);
        end
        for (int k = 0; k < 20 && m_cnt > 0; k++) begin
            step(1'b0, hd, 1'b1, 1'b0, hd, pp, pu);
            if (pp) begin
                exp = sb.pop_front();
                n_checks++;
                if (hd !== exp) begin n_fail++; $display("FAIL drain_pop: got %h want %h", hd, exp); end
            end
        end
    endtask

    task automatic test_flush();
        bun_t hd, exp, nb;
        logic pp, pu;
        for (int i = 0; i < 3; i++) step(1'b1, mk(32'h200 + 32'(i) * 4), 1'b0, 1'b0, hd, pp, pu);
        n_checks++;
        if (count_o !== 3'd3) begin n_fail++; $display("FAIL flush_pre: got cnt=%0d want 3", count_o); end
        step(1'b1, mk(32'h20c), 1'b1, 1'b1, hd, pp, pu);
        n_checks++;
        if ({count_o, pop_valid_o, instr_o, pc_o} !== {3'd0, 1'b0, 32'h13, 32'h0}) begin
            n_fail++;
            $display("FAIL flush_state: got cnt=%0d vld=%b instr=%h pc=%h want 0/0/00000013/0",
                     count_o, pop_valid_o, instr_o, pc_o);
        end
        nb = mk(32'h300);
        step(1'b1, nb, 1'b0, 1'b0, hd, pp, pu);
        n_checks++;
        if (count_o !== 3'd1 || {instr_o, pc_o, btb_pc_o, pred_taken_o} !== nb) begin
            n_fail++;
            $display("FAIL post_flush_push: got cnt=%0d head=%h want 1/%h", count_o,
                     {instr_o, pc_o, btb_pc_o, pred_taken_o}, nb);
        end
        for (int k = 0; k < 20 && m_cnt > 0; k++) begin
            step(1'b0, hd, 1'b1, 1'b0, hd, pp, pu);
            if (pp) begin
                exp = sb.pop_front();
                n_checks++;
                if (hd !== exp) begin n_fail++; $display("FAIL flush_drain: got %h want %h", hd, exp); end
            end
        end
    endtask

    task automatic test_random();
        bun_t hd, exp, cur;
        logic pp, pu;
        int   sent = 0, got = 0, cyc = 0;
        cur = mk(32'h1000);
        while ((sent < 10 || m_cnt > 0) && cyc < 300) begin
            step(sent < 10 && $urandom_range(0, 1) == 1, cur, 1'($urandom_range(0, 1)), 1'b0, hd, pp, pu);
            if (pu) begin sent++; cur = mk(32'h1000 + 32'(sent) * 4); end
            if (pp) begin
                exp = sb.pop_front();
                got++;
                n_checks++;
                if (hd !== exp) begin n_fail++; $display("FAIL random_pop: got %h want %h", hd, exp); end
            end
            cyc++;
        end
        n_checks++;
        if (got != 10 || count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL random_done: got pops=%0d cnt=%0d want 10/0", got, count_o);
        end
    endtask

    task automatic test_midstream_reset();
        bun_t hd, exp, nb;
        logic pp, pu;
        for (int i = 0; i < 2; i++) step(1'b1, mk(32'h400 + 32'(i) * 4), 1'b0, 1'b0, hd, pp, pu);
        n_checks++;
        if (count_o !== 3'd2) begin n_fail++; $display("FAIL mid_pre: got cnt=%0d want 2", count_o); end
        rst_i = 1'b1;
        #1;
        n_checks++;
        if ({count_o, pop_valid_o, push_ready_o, instr_o, pc_o} !== {3'd0, 1'b0, 1'b1, 32'h13, 32'h0}) begin
            n_fail++;
            $display("FAIL mid_reset: got cnt=%0d vld=%b rdy=%b instr=%h pc=%h want 0/0/1/00000013/0",
                     count_o, pop_valid_o, push_ready_o, instr_o, pc_o);
        end
        m_cnt = 0;
        sb.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        nb = mk(32'h500);
        step(1'b1, nb, 1'b0, 1'b0, hd, pp, pu);
        step(1'b0, nb, 1'b1, 1'b0, hd, pp, pu);
        if (pp) begin
            exp = sb.pop_front();
            n_checks++;
            if (hd !== exp) begin n_fail++; $display("FAIL resume_pop: got %h want %h", hd, exp); end
        end
        n_checks++;
        if (count_o !== 3'd0 || !pp) begin
            n_fail++;
            $display("FAIL resume_done: got cnt=%0d popped=%b want 0/1", count_o, pp);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_backpressure();
        test_flush();
        test_random();
        test_midstream_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
